chan_scan_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit registered selector. It generalises the 6-to-1 byte multiplexer with a registered output and two modes: manual selection via `sel`, and autonomous round-robin scan with a programmable dwell per channel. It also flags out-of-range selects, and supports hold and wrap notification. It sits between the datapath sources and a single downstream consumer, such as a display or logger, that samples one channel at a time.

---
 rtl/chan_scan_mux.sv | 126 ++++++++++++
 tb/tb_chan_scan_mux.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/chan_scan_mux.sv
// N-channel registered selector: manual select by sel, or round-robin scan with DWELL cycles per channel.
// Latency: one cycle from din/sel to dout/dout_ch/valid/sel_err; wrap is registered alongside dout.
// Backpressure: none; en=0 freezes pointer, dwell count and data, and forces valid/wrap low.
module chan_scan_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 6,
  parameter int SELW  = 3,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   din,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 en,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      dout_ch,
  output logic                 valid,
  output logic                 sel_err,
  output logic                 wrap
);

  localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
  localparam logic [SELW-1:0] PTR_LAST = SELW'(N - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_d;
  logic [SELW-1:0]   dout_ch_d;
  logic              valid_d, sel_err_d, wrap_d;

  logic [WIDTH-1:0]  sel_dat;
  logic [WIDTH-1:0]  scan_dat;
  logic              sel_ok;

  // Channel muxes: out-of-range indices fall through to zero.
  always_comb begin
    sel_dat  = '0;
    scan_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i))   sel_dat  = din[i*WIDTH +: WIDTH];
      if (ptr_q == SELW'(i)) scan_dat = din[i*WIDTH +: WIDTH];
    end
  end

  assign sel_ok = ({1'b0, sel} < N_EXT);

  // Next-state and next-output logic; valid and wrap are pulses, everything else holds by default.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    dout_d    = dout;
    dout_ch_d = dout_ch;
    valid_d   = 1'b0;
    sel_err_d = sel_err;
    wrap_d    = 1'b0;
    if (en) begin
      if (!mode) begin
        // Manual clears the scan position so the next scan starts at channel 0 with a full dwell.
        state_d   = MANUAL;
        ptr_d     = '0;
        cnt_d     = '0;
        dout_ch_d = sel;
        if (sel_ok) begin
          dout_d    = sel_dat;
          valid_d   = 1'b1;
          sel_err_d = 1'b0;
        end else begin
          dout_d    = '0;
          valid_d   = 1'b0;
          sel_err_d = 1'b1;
        end
      end else begin
        state_d   = SCAN;
        dout_d    = scan_dat;
        dout_ch_d = ptr_q;
        valid_d   = 1'b1;
        sel_err_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (ptr_q == PTR_LAST) begin
            ptr_d  = '0;
            wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dout    <= '0;
      dout_ch <= '0;
      valid   <= 1'b0;
      sel_err <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dout    <= dout_d;
      dout_ch <= dout_ch_d;
      valid   <= valid_d;
      sel_err <= sel_err_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux with N=6, WIDTH=8, SELW=3, DWELL=2.
// Reference model tracks scan position as a single phase within an N*DWELL round.
// Directed scenarios from the test plan, followed by randomized traffic.
module tb_chan_scan_mux;

  localparam int WIDTH = 8;
  localparam int N     = 6;
  localparam int SELW  = 3;
  localparam int DWELL = 2;
  localparam int ROUND = N * DWELL;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*WIDTH-1:0] din;
  logic [SELW-1:0]    sel;
  logic               mode;
  logic               en;
  logic [WIDTH-1:0]   dout;
  logic [SELW-1:0]    dout_ch;
  logic               valid;
  logic               sel_err;
  logic               wrap;

  logic [WIDTH-1:0] ch [N];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_phase = 0;
  int m_dout = 0, m_ch = 0, m_valid = 0, m_err = 0, m_wrap = 0;

  chan_scan_mux #(.WIDTH(WIDTH), .N(N), .SELW(SELW), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .en(en),
    .dout(dout), .dout_ch(dout_ch), .valid(valid), .sel_err(sel_err), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int c;
    if (!rst_n) begin
      m_dout = 0; m_ch = 0; m_valid = 0; m_err = 0; m_wrap = 0; m_phase = 0;
    end else if (!en) begin
      m_valid = 0; m_wrap = 0;
    end else if (!mode) begin
      m_phase = 0; m_wrap = 0; m_ch = int'(sel);
      if (int'(sel) < N) begin
        m_dout = int'(ch[sel]); m_valid = 1; m_err = 0;
      end else begin
        m_dout = 0; m_valid = 0; m_err = 1;
      end
    end else begin
      c = m_phase / DWELL;
      m_dout = int'(ch[c]); m_ch = c; m_valid = 1; m_err = 0;
      m_wrap = (m_phase == ROUND - 1) ? 1 : 0;
      m_phase = (m_phase + 1) % ROUND;
    end
  endtask

  // One clock edge: drive din from ch, update model, then sample outputs after the edge.
  task automatic tick();
    for (int i = 0; i < N; i++) din[i*WIDTH +: WIDTH] = ch[i];
    model_edge();
    @(posedge clk);
    #1;
    chk("dout",    32'(dout),    32'(m_dout));
    chk("dout_ch", 32'(dout_ch), 32'(m_ch));
    chk("valid",   32'(valid),   32'(m_valid));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    chk("wrap",    32'(wrap),    32'(m_wrap));
  endtask

  initial begin
    int scan_exp [14];
    int wraps;
    scan_exp = '{10, 10, 20, 20, 30, 30, 40, 40, 50, 50, 60, 60, 10, 10};
    for (int i = 0; i < N; i++) ch[i] = 8'((i + 1) * 10);
    rst_n = 1'b0; mode = 1'b1; en = 1'b1; sel = '0; din = '0;

    // Reset held for two edges with scan and enable asserted.
    tick();
    tick();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);

    // Manual sweep over all legal channels.
    rst_n = 1'b1; mode = 1'b0;
    for (int s = 0; s < N; s++) begin
      sel = SELW'(s);
      tick();
      chk("sweep_dout", 32'(dout), 32'((s + 1) * 10));
    end
    sel = 3'd7;
    tick();
    chk("oob_err", 32'(sel_err), 32'd1);
    ch[0] = 8'd100; sel = 3'd0;
    tick();
    chk("ch0_100", 32'(dout), 32'd100);
    ch[0] = 8'd10;

    // Scan round: 14 cycles, wrap only on the second 60.
    mode = 1'b1; wraps = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("scan_seq", 32'(dout), 32'(scan_exp[k]));
      chk("scan_wrap", 32'(wrap), (k == 11) ? 32'd1 : 32'd0);
      if (wrap) wraps++;
    end
    chk("wrap_count", 32'(wraps), 32'd1);

    // Freeze mid-dwell after the first 30.
    mode = 1'b0; sel = 3'd0; tick();
    mode = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_freeze", 32'(dout), 32'd30);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_dout", 32'(dout), 32'd30);
      chk("frz_valid", 32'(valid), 32'd0);
    end
    en = 1'b1;
    tick(); chk("resume0", 32'(dout), 32'd30);
    tick(); chk("resume1", 32'(dout), 32'd40);
    tick(); chk("resume2", 32'(dout), 32'd40);

    // Mode switch: manual sel=1, then scan restarts from channel 0.
    mode = 1'b0; sel = 3'd1;
    tick(); chk("sw_manual", 32'(dout), 32'd20);
    mode = 1'b1;
    tick(); chk("sw_scan0", 32'(dout), 32'd10);
    tick(); chk("sw_scan1", 32'(dout), 32'd10);
    tick(); chk("sw_scan2", 32'(dout), 32'd20);

    // Mid-operation reset at dout=50.
    for (int k = 0; k < 6; k++) tick();
    chk("pre_rst", 32'(dout), 32'd50);
    rst_n = 1'b0;
    tick(); chk("mid_rst", 32'(dout), 32'd0);
    rst_n = 1'b1;
    tick(); chk("post_rst0", 32'(dout), 32'd10);
    tick(); chk("post_rst1", 32'(dout), 32'd10);
    tick(); chk("post_rst2", 32'(dout), 32'd20);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en    = ($urandom_range(0, 5) != 0);
      mode  = ($urandom_range(0, 3) != 0);
      sel   = SELW'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) ch[i] = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
